// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, result published at once.
// Ports: clk, rst, start, a, b, cin in; ready, busy, done, sum, cout out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    s_bit    = opa[0] ^ opb[0] ^ carry;
    c_next   = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    // New bit enters at the top; after WIDTH shifts bit 0 sits at the LSB.
    acc_next = {s_bit, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (start && ready) begin
      // ready is high exactly in IDLE and DONE, so this covers both
      // a fresh start and a back-to-back start out of DONE.
      state <= SHIFT;
      ready <= 1'b0;
      busy  <= 1'b1;
      done  <= 1'b0;
      opa   <= a;
      opb   <= b;
      carry <= cin;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
        end
        SHIFT: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= acc_next;
          carry <= c_next;
          if (cnt == LAST) begin
            // Only the finished word ever reaches sum.
            sum   <= acc_next;
            cout  <= c_next;
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8).
// Each scenario task drives stimulus and checks its own results.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int total;
  int bad;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start, let one rising edge accept them.
  task automatic begin_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input bit hold);
    @(negedge clk);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done. lat counts edges after acceptance.
  // At lat==chg_at the inputs are disturbed; at lat==clr_at start drops.
  task automatic wait_done(input int chg_at, input logic [7:0] ca,
                           input logic [7:0] cb, input logic cs,
                           input int clr_at,
                           output int lat, output int busy_cnt,
                           output bit sum_moved);
    logic [7:0] s0;
    logic       c0;
    lat       = 0;
    busy_cnt  = 0;
    sum_moved = 1'b0;
    s0        = sum;
    c0        = cout;
    while (lat < 20) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      if (sum !== s0 || cout !== c0) sum_moved = 1'b1;
      lat++;
      if (lat == chg_at) begin
        a     = ca;
        b     = cb;
        start = cs;
      end
      if (lat == clr_at) start = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h22;
    cin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got r=%b b=%b d=%b want 1 0 0",
               ready, busy, done);
    end
    total++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_result: got %b_%h want 0_00", cout, sum);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_priority: got busy=%b ready=%b want 0 1",
               busy, ready);
    end
  endtask

  task automatic test_zero();
    int lat;
    int bc;
    bit mv;
    begin_op(8'h00, 8'h00, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_accept: got busy=%b ready=%b want 1 0",
               busy, ready);
    end
    wait_done(-1, 8'h00, 8'h00, 1'b0, -1, lat, bc, mv);
    total++;
    if (lat !== 8 || bc !== 8) begin
      bad++;
      $display("FAIL zero_timing: got lat=%0d busy=%0d want 8 8", lat, bc);
    end
    total++;
    if (sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_result: got %b_%h busy=%b want 0_00 0",
               cout, sum, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done_width: got d=%b r=%b b=%b want 0 1 0",
               done, ready, busy);
    end
  endtask

  task automatic test_carry_out();
    int lat;
    int bc;
    bit mv;
    begin_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(-1, 8'h00, 8'h00, 1'b0, -1, lat, bc, mv);
    total++;
    if (lat !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
      bad++;
      $display("FAIL ff_plus_1: got lat=%0d %b_%h want 8 1_00",
               lat, cout, sum);
    end
    begin_op(8'h3C, 8'h0F, 1'b1, 1'b0);
    wait_done(-1, 8'h00, 8'h00, 1'b0, -1, lat, bc, mv);
    total++;
    if (sum !== 8'h4C || cout !== 1'b0 || mv) begin
      bad++;
      $display("FAIL 3c_0f_1: got %b_%h moved=%0d want 0_4c moved=0",
               cout, sum, mv);
    end
    begin_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(-1, 8'h00, 8'h00, 1'b0, -1, lat, bc, mv);
    total++;
    if (sum !== 8'hFF || cout !== 1'b1 || mv) begin
      bad++;
      $display("FAIL ff_ff_1: got %b_%h moved=%0d want 1_ff moved=0",
               cout, sum, mv);
    end
  endtask

  task automatic test_operand_change();
    int lat;
    int bc;
    bit mv;
    begin_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_done(3, 8'h00, 8'h00, 1'b0, -1, lat, bc, mv);
    total++;
    if (lat !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
      bad++;
      $display("FAIL a5_5a_1_mid_change: got lat=%0d %b_%h want 8 1_00",
               lat, cout, sum);
    end
    total++;
    if (mv) begin
      bad++;
      $display("FAIL a5_sum_stable: got moved=1 want 0");
    end
  endtask

  task automatic test_start_in_shift();
    int lat;
    int bc;
    bit mv;
    begin_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(3, 8'h11, 8'h34, 1'b1, 5, lat, bc, mv);
    total++;
    if (lat !== 8 || sum !== 8'h46 || cout !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored: got lat=%0d %b_%h want 8 0_46",
               lat, cout, sum);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored_idle: got b=%b r=%b d=%b want 0 1 0",
               busy, ready, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    bit mv;
    begin_op(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(2, 8'h03, 8'h04, 1'b1, -1, lat, bc, mv);
    total++;
    if (lat !== 8 || sum !== 8'h30 || cout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d %b_%h want 8 0_30",
               lat, cout, sum);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: got busy=%b done=%b want 1 0",
               busy, done);
    end
    wait_done(-1, 8'h00, 8'h00, 1'b0, -1, lat, bc, mv);
    total++;
    if (lat !== 8 || sum !== 8'h07 || cout !== 1'b0 || mv) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d %b_%h moved=%0d want 8 0_07 0",
               lat, cout, sum, mv);
    end
  endtask

  task automatic test_reset_in_shift();
    int seen;
    begin_op(8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 ||
        sum !== 8'h00 || cout !== 1'b0) begin
      bad++;
      $display("FAIL rst_abort: got b=%b r=%b d=%b %b_%h want 0 1 0 0_00",
               busy, ready, done, cout, sum);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_no_done: got active=%0d want 0", seen);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    test_reset();
    test_zero();
    test_carry_out();
    test_operand_change();
    test_start_in_shift();
    test_back_to_back();
    test_reset_in_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
